// File: rtl/ad7276_capture.sv
// ad7276_capture
//   Serial capture front end for one AD7276 12-bit ADC. A programmable period
//   counter triggers a conversion every i_sample_period+1 clocks. Each trigger
//   drives one 16-bit cs_n/sclk frame, shifts the frame in MSB-first, keeps the
//   12 data bits and offers them on a valid/ready output to the decimator.
//
// Ports
//   i_clk              system clock, rising edge
//   i_rst              synchronous active-high reset
//   i_enable           1 = run periodic conversions
//   i_sample_period    conversion period minus one, in clocks (used live)
//   i_sdata            ADC serial data (already synchronised)
//   o_cs_n             ADC chip select, registered
//   o_sclk             ADC serial clock, registered, idles high
//   o_out_data         captured sample
//   o_out_data_valid   o_out_data holds a sample not yet accepted
//   i_out_data_ready   consumer accepts when valid && ready
//   o_overrun          one-cycle pulse: an unaccepted sample was overwritten
//
// state      | meaning
// S_IDLE     | cs_n high, waiting for a trigger or a pending trigger
// S_CS_SETUP | cs_n low, sclk high for CLK_DIV clocks before the first edge
// S_SHIFT    | 16 sclk periods, CLK_DIV clocks low then CLK_DIV clocks high
// S_QUIET    | cs_n high for QUIET_CYCLES clocks before the next frame
module ad7276_capture #(
  parameter int DATA_WIDTH     = 12,
  parameter int DATA_REG_WIDTH = 32,
  parameter int CLK_DIV        = 2,
  parameter int QUIET_CYCLES   = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  input  logic [DATA_REG_WIDTH-1:0] i_sample_period,
  input  logic                      i_sdata,
  output logic                      o_cs_n,
  output logic                      o_sclk,
  output logic [DATA_WIDTH-1:0]     o_out_data,
  output logic                      o_out_data_valid,
  input  logic                      i_out_data_ready,
  output logic                      o_overrun
);

  localparam int FRAME_BITS = 16;
  // Only frame bits [13:0] are ever needed; the two leading zeros fall off the top.
  localparam int SHREG_W    = DATA_WIDTH + 2;
  localparam int DIV_MAX    = (CLK_DIV > QUIET_CYCLES) ? CLK_DIV : QUIET_CYCLES;
  localparam int DIV_W      = $clog2(DIV_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] QUIET_LAST = DIV_W'(QUIET_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST   = 4'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CS_SETUP = 2'd1,
    S_SHIFT    = 2'd2,
    S_QUIET    = 2'd3
  } state_t;

  state_t                    r_state;
  logic [DIV_W-1:0]          r_div;
  logic                      r_phase;      // 0 = sclk low half, 1 = sclk high half
  logic [3:0]                r_bit;
  logic [DATA_REG_WIDTH-1:0] r_period_cnt;
  logic                      r_pending;
  logic [SHREG_W-1:0]        r_shreg;
  logic                      r_cs_n;
  logic                      r_sclk;
  logic [DATA_WIDTH-1:0]     r_out_data;
  logic                      r_out_valid;
  logic                      r_overrun;

  state_t                    w_state_nxt;
  logic [DIV_W-1:0]          w_div_nxt;
  logic                      w_phase_nxt;
  logic [3:0]                w_bit_nxt;
  logic                      w_trig;
  logic                      w_start;
  logic                      w_cs_n_nxt;
  logic                      w_sclk_nxt;
  logic                      w_shift_en;
  logic                      w_load;

  // >= rather than == so a shrinking period never strands the counter above it.
  assign w_trig  = i_enable && (r_period_cnt >= i_sample_period);
  // Gating pending with enable keeps a dropped enable from starting one more frame.
  assign w_start = w_trig || (r_pending && i_enable);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_period_cnt <= '0;
    end else if (!i_enable || w_trig) begin
      r_period_cnt <= '0;
    end else begin
      r_period_cnt <= r_period_cnt + 1'b1;
    end
  end

  // In IDLE any trigger/pending is consumed by the frame start; a trigger that
  // coincides with an already pending one is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_enable) begin
      r_pending <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_pending <= 1'b0;
    end else if (w_trig) begin
      r_pending <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_phase <= 1'b0;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_phase <= w_phase_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    case (r_state)
      S_IDLE: begin
        w_div_nxt   = '0;
        w_phase_nxt = 1'b0;
        w_bit_nxt   = '0;
        if (w_start) begin
          w_state_nxt = S_CS_SETUP;
        end
      end
      S_CS_SETUP: begin
        if (r_div == DIV_LAST) begin
          w_state_nxt = S_SHIFT;
          w_div_nxt   = '0;
          w_phase_nxt = 1'b0;
          w_bit_nxt   = '0;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      S_SHIFT: begin
        if (r_div == DIV_LAST) begin
          w_div_nxt = '0;
          if (!r_phase) begin
            w_phase_nxt = 1'b1;
          end else if (r_bit == BIT_LAST) begin
            w_state_nxt = S_QUIET;
          end else begin
            w_phase_nxt = 1'b0;
            w_bit_nxt   = r_bit + 1'b1;
          end
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      S_QUIET: begin
        if (r_div == QUIET_LAST) begin
          w_state_nxt = S_IDLE;
          w_div_nxt   = '0;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode. cs_n/sclk are decoded from the next state so the registered
  // pins line up with the state they belong to.
  always_comb begin
    w_cs_n_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_QUIET);
    w_sclk_nxt = (w_state_nxt == S_SHIFT) ? w_phase_nxt : 1'b1;
    // Sample on the last clock of each low half, the clock that raises sclk.
    w_shift_en = (r_state == S_SHIFT) && !r_phase && (r_div == DIV_LAST);
    // Leaving SHIFT: all 16 bits are in, so the sample is ready on the first QUIET clock.
    w_load     = (r_state == S_SHIFT) && r_phase && (r_div == DIV_LAST) && (r_bit == BIT_LAST);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cs_n  <= 1'b1;
      r_sclk  <= 1'b1;
      r_shreg <= '0;
    end else begin
      r_cs_n <= w_cs_n_nxt;
      r_sclk <= w_sclk_nxt;
      if (w_shift_en) begin
        r_shreg <= {r_shreg[SHREG_W-2:0], i_sdata};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_load) begin
        r_out_data  <= r_shreg[DATA_WIDTH+1:2];
        r_out_valid <= 1'b1;
        // Accepted-and-replaced in the same clock is not an overrun.
        r_overrun   <= r_out_valid && !i_out_data_ready;
      end else if (r_out_valid && i_out_data_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_cs_n           = r_cs_n;
  assign o_sclk           = r_sclk;
  assign o_out_data       = r_out_data;
  assign o_out_data_valid = r_out_valid;
  assign o_overrun        = r_overrun;

endmodule
